instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Pipelined RV32I decode stage between the instruction memory and the register-file/ALU stage of the core. Accepts one fetched instruction word plus its PC per valid/ready handshake, cracks it into register addresses, funct fields, sign-extended immediate and control strobes, and holds the result in a one-entry pipeline register. Supports downstream backpressure and a flush for taken branches, and flags illegal encodings.

## Interface
- `I_WIDTH`, 32, instruction word width
- `PC_WIDTH`, 32, program counter width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  discard held and incoming instruction
- `in_valid`  in  1  fetch word present
- `in_ready`  out  1  stage can accept
- `in_instr`  in  I_WIDTH  instruction word
- `in_pc`  in  PC_WIDTH  address of `in_instr`
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  downstream accepts bundle
- `out_pc`  out  PC_WIDTH  registered PC
- `out_opcode`  out  7  instr[6:0]
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register addresses, raw fields
- `out_f3`  out  3  instr[14:12]
- `out_f7`  out  7  instr[31:25]
- `out_imm`  out  32  sign-extended immediate
- `out_alu`, `out_branch`, `out_jump`, `out_mem_rd`, `out_mem_wr`, `out_reg_wr`  out  1 each  control strobes
- `out_sel_pc`  out  1  ALU operand A = PC (AUIPC, JAL)
- `out_sel_imm`  out  1  ALU operand B = immediate
- `out_illegal`  out  1  unsupported/illegal encoding

## Operation
- Accept when `in_valid & in_ready`; decode is combinational, result registered.
- Formats: I (OP-IMM, LOAD, JALR, SYSTEM, MISC-MEM), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL), R (OP). R-type imm = 0.
- Strobes: OP/OP-IMM/LUI/AUIPC → alu; BRANCH → branch; JAL/JALR → jump; LOAD → mem_rd; STORE → mem_wr; reg_wr for all except BRANCH, STORE, MISC-MEM, SYSTEM. sel_imm for all except OP and BRANCH.
- `out_reg_wr` forced 0 when rd = x0.
- Illegal: instr[1:0] ≠ 2'b11; unknown opcode; OP with f7 ∉ {0x00, 0x20} or f7 = 0x20 with f3 ∉ {000, 101}; shift-imm with bad f7; BRANCH f3 ∈ {010, 011}; LOAD f3 ∈ {011, 110, 111}; STORE f3 > 010. When illegal: `out_illegal` = 1, all other strobes 0, fields still registered.

## Timing
- Latency 1 cycle from acceptance to `out_valid`.
- `in_ready` = `~out_valid | out_ready` (combinational); back-to-back at full rate with `out_ready` high.
- While `out_valid & ~out_ready`: all outputs held stable.
- `flush` has priority: next cycle `out_valid` = 0 regardless of `in_valid`/`out_ready`; instruction offered that cycle is dropped. `in_ready` is unaffected by `flush`.
- Reset (async): every output register → 0, so `out_valid` = 0 and `in_ready` = 1 after reset. Reset mid-transfer drops the held bundle without completing the handshake.

## Structure
- Shared package `riscv_pkg`: `riscVDat`, `PC`, `Opcode`, `rdAdr`, `rsAdr`, `func3`, `func7`, `immediate` typedefs; opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111, SYSTEM 1110011); a packed decoded-bundle struct.
- One sub-module: `imm_gen` (combinational format select plus sign extension).

## Test plan
- ADDI x1,x0,-1 (0xFFF00093) → next cycle `out_valid`=1, rd=1, imm=0xFFFFFFFF, alu=1, reg_wr=1, sel_imm=1.
- BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, branch=1, reg_wr=0; LUI x5,0x12345 (0x123452B7) → imm=0x12345000, rd=5, reg_wr=1.
- `out_ready` low 3 cycles with two instructions queued → `in_ready`=0, outputs stable; second instruction appears one cycle after `out_ready` rises.
- `flush`=1 together with `in_valid`=1 and a held bundle → `out_valid`=0 next cycle, both instructions dropped.
- 0x00000000 and 0x02000033 (MUL) → `out_illegal`=1, all strobes 0; ADDI x0,x0,0 (0x00000013) → reg_wr=0, legal.
- Assert `rst_n` low while `out_valid`=1 → all outputs 0 immediately, `in_ready`=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types, opcode constants and the decoded-instruction bundle.
package riscv_pkg;

  typedef logic [31:0] riscVDat;
  typedef logic [31:0] PC;
  typedef logic [6:0]  Opcode;
  typedef logic [4:0]  rdAdr;
  typedef logic [4:0]  rsAdr;
  typedef logic [2:0]  func3;
  typedef logic [6:0]  func7;
  typedef logic [31:0] immediate;

  localparam Opcode OPC_LUI      = 7'b0110111;
  localparam Opcode OPC_AUIPC    = 7'b0010111;
  localparam Opcode OPC_JAL      = 7'b1101111;
  localparam Opcode OPC_JALR     = 7'b1100111;
  localparam Opcode OPC_BRANCH   = 7'b1100011;
  localparam Opcode OPC_LOAD     = 7'b0000011;
  localparam Opcode OPC_STORE    = 7'b0100011;
  localparam Opcode OPC_OP_IMM   = 7'b0010011;
  localparam Opcode OPC_OP       = 7'b0110011;
  localparam Opcode OPC_MISC_MEM = 7'b0001111;
  localparam Opcode OPC_SYSTEM   = 7'b1110011;

  // Immediate encoding formats; R covers OP and unknown opcodes (imm = 0).
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Everything the register-file/ALU stage needs from one instruction.
  typedef struct packed {
    Opcode    opcode;
    rdAdr     rd;
    rsAdr     rs1;
    rsAdr     rs2;
    func3     f3;
    func7     f7;
    immediate imm;
    logic     alu;
    logic     branch;
    logic     jump;
    logic     mem_rd;
    logic     mem_wr;
    logic     reg_wr;
    logic     sel_pc;
    logic     sel_imm;
    logic     illegal;
  } decoded_t;

  // Map an opcode to the layout of its immediate bits.
  function automatic imm_fmt_e imm_fmt(input Opcode opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:       imm_fmt = FMT_I;
      OPC_STORE:                      imm_fmt = FMT_S;
      OPC_BRANCH:                     imm_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             imm_fmt = FMT_U;
      OPC_JAL:                        imm_fmt = FMT_J;
      default:                        imm_fmt = FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator: picks the format from the opcode and sign-extends.
module imm_gen
  import riscv_pkg::*;
(
  input  riscVDat  instr,
  output immediate imm
);

  // Reassemble the scattered immediate bits for the instruction's format.
  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode of the offered word into a
// one-entry pipeline register with valid/ready flow control and flush.
// Decode looks at the low 32 bits of the instruction word.
module instr_decode_stage
  import riscv_pkg::*;
#(
  parameter int I_WIDTH  = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [I_WIDTH-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_f3,
  output logic [6:0]          out_f7,
  output logic [31:0]         out_imm,
  output logic                out_alu,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_mem_rd,
  output logic                out_mem_wr,
  output logic                out_reg_wr,
  output logic                out_sel_pc,
  output logic                out_sel_imm,
  output logic                out_illegal
);

  riscVDat                instr_word;
  immediate               imm_d;
  decoded_t               dec_d;
  decoded_t               dec_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic                   valid_q;

  assign instr_word = in_instr[31:0];

  imm_gen u_imm_gen (
    .instr (instr_word),
    .imm   (imm_d)
  );

  // Crack the word into fields and control strobes, then qualify legality.
  always_comb begin
    dec_d         = '0;
    dec_d.opcode  = instr_word[6:0];
    dec_d.rd      = instr_word[11:7];
    dec_d.f3      = instr_word[14:12];
    dec_d.rs1     = instr_word[19:15];
    dec_d.rs2     = instr_word[24:20];
    dec_d.f7      = instr_word[31:25];
    dec_d.imm     = imm_d;

    case (dec_d.opcode)
      OPC_LUI: begin
        dec_d.alu = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.alu = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_pc = 1'b1; dec_d.sel_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_d.jump = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_pc = 1'b1; dec_d.sel_imm = 1'b1;
      end
      OPC_JALR: begin
        dec_d.jump = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.branch = 1'b1;
        if (dec_d.f3 == 3'b010 || dec_d.f3 == 3'b011) dec_d.illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec_d.mem_rd = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_imm = 1'b1;
        if (dec_d.f3 == 3'b011 || dec_d.f3 == 3'b110 || dec_d.f3 == 3'b111) dec_d.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec_d.mem_wr = 1'b1; dec_d.sel_imm = 1'b1;
        if (dec_d.f3 > 3'b010) dec_d.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.alu = 1'b1; dec_d.reg_wr = 1'b1; dec_d.sel_imm = 1'b1;
        // Shift-immediates reuse the upper bits as funct7.
        if (dec_d.f3 == 3'b001 && dec_d.f7 != 7'h00) dec_d.illegal = 1'b1;
        if (dec_d.f3 == 3'b101 && dec_d.f7 != 7'h00 && dec_d.f7 != 7'h20) dec_d.illegal = 1'b1;
      end
      OPC_OP: begin
        dec_d.alu = 1'b1; dec_d.reg_wr = 1'b1;
        if (dec_d.f7 != 7'h00 && dec_d.f7 != 7'h20) dec_d.illegal = 1'b1;
        if (dec_d.f7 == 7'h20 && dec_d.f3 != 3'b000 && dec_d.f3 != 3'b101) dec_d.illegal = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec_d.sel_imm = 1'b1;
      end
      default: begin
        dec_d.illegal = 1'b1;
      end
    endcase

    // Compressed or reserved encodings never reach a legal opcode.
    if (instr_word[1:0] != 2'b11) dec_d.illegal = 1'b1;

    // Writes to x0 are discarded, so do not request one.
    if (dec_d.rd == 5'd0) dec_d.reg_wr = 1'b0;

    if (dec_d.illegal) begin
      dec_d.alu     = 1'b0;
      dec_d.branch  = 1'b0;
      dec_d.jump    = 1'b0;
      dec_d.mem_rd  = 1'b0;
      dec_d.mem_wr  = 1'b0;
      dec_d.reg_wr  = 1'b0;
      dec_d.sel_pc  = 1'b0;
      dec_d.sel_imm = 1'b0;
    end
  end

  assign in_ready = ~valid_q | out_ready;

  // Pipeline register: flush wins, otherwise advance whenever the slot frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      dec_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        pc_q  <= in_pc;
        dec_q <= dec_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_opcode  = dec_q.opcode;
  assign out_rd      = dec_q.rd;
  assign out_rs1     = dec_q.rs1;
  assign out_rs2     = dec_q.rs2;
  assign out_f3      = dec_q.f3;
  assign out_f7      = dec_q.f7;
  assign out_imm     = dec_q.imm;
  assign out_alu     = dec_q.alu;
  assign out_branch  = dec_q.branch;
  assign out_jump    = dec_q.jump;
  assign out_mem_rd  = dec_q.mem_rd;
  assign out_mem_wr  = dec_q.mem_wr;
  assign out_reg_wr  = dec_q.reg_wr;
  assign out_sel_pc  = dec_q.sel_pc;
  assign out_sel_imm = dec_q.sel_imm;
  assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: decode vector table plus handshake,
// flush and reset sequences.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_f3;
  logic [6:0]  out_f7;
  logic [31:0] out_imm;
  logic        out_alu, out_branch, out_jump, out_mem_rd, out_mem_wr;
  logic        out_reg_wr, out_sel_pc, out_sel_imm, out_illegal;
  logic [8:0]  ctrl_act;

  int total = 0;
  int bad   = 0;

  // Control bit positions in {alu,branch,jump,mem_rd,mem_wr,reg_wr,sel_pc,sel_imm,illegal}
  localparam logic [8:0] ALU = 9'h100, BR  = 9'h080, JMP = 9'h040,
                         MRD = 9'h020, MWR = 9'h010, RW  = 9'h008,
                         SPC = 9'h004, SIM = 9'h002, ILL = 9'h001;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [8:0]  ctrl;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  instr_decode_stage #(.I_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_f3      (out_f3),
    .out_f7      (out_f7),
    .out_imm     (out_imm),
    .out_alu     (out_alu),
    .out_branch  (out_branch),
    .out_jump    (out_jump),
    .out_mem_rd  (out_mem_rd),
    .out_mem_wr  (out_mem_wr),
    .out_reg_wr  (out_reg_wr),
    .out_sel_pc  (out_sel_pc),
    .out_sel_imm (out_sel_imm),
    .out_illegal (out_illegal)
  );

  assign ctrl_act = {out_alu, out_branch, out_jump, out_mem_rd, out_mem_wr,
                     out_reg_wr, out_sel_pc, out_sel_imm, out_illegal};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge; registered outputs are then stable to sample.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  initial begin
    logic [31:0] pc;

    vecs[0]  = '{32'hFFF00093, 5'd1,  32'hFFFFFFFF, ALU | RW | SIM};
    vecs[1]  = '{32'hFE000EE3, 5'd29, 32'hFFFFFFFC, BR};
    vecs[2]  = '{32'h123452B7, 5'd5,  32'h12345000, ALU | RW | SIM};
    vecs[3]  = '{32'h00000000, 5'd0,  32'h00000000, ILL};
    vecs[4]  = '{32'h02000033, 5'd0,  32'h00000000, ILL};
    vecs[5]  = '{32'h00000013, 5'd0,  32'h00000000, ALU | SIM};
    vecs[6]  = '{32'h0020A423, 5'd8,  32'h00000008, MWR | SIM};
    vecs[7]  = '{32'hFFC12183, 5'd3,  32'hFFFFFFFC, MRD | RW | SIM};
    vecs[8]  = '{32'h010000EF, 5'd1,  32'h00000010, JMP | RW | SPC | SIM};
    vecs[9]  = '{32'hFFFFF517, 5'd10, 32'hFFFFF000, ALU | RW | SPC | SIM};
    vecs[10] = '{32'h402081B3, 5'd3,  32'h00000000, ALU | RW};
    vecs[11] = '{32'h4020A1B3, 5'd3,  32'h00000000, ILL};
    vecs[12] = '{32'h4030D093, 5'd1,  32'h00000403, ALU | RW | SIM};
    vecs[13] = '{32'h40309093, 5'd1,  32'h00000403, ILL};
    vecs[14] = '{32'hFE002EE3, 5'd29, 32'hFFFFFFFC, ILL};
    vecs[15] = '{32'hFFC13183, 5'd3,  32'hFFFFFFFC, ILL};
    vecs[16] = '{32'h0020B423, 5'd8,  32'h00000008, ILL};
    vecs[17] = '{32'h00000073, 5'd0,  32'h00000000, SIM};
    vecs[18] = '{32'h0000000F, 5'd0,  32'h00000000, SIM};
    vecs[19] = '{32'h00008067, 5'd0,  32'h00000000, JMP | SIM};
    vecs[20] = '{32'h00000001, 5'd0,  32'h00000000, ILL};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #12;
    $display("[TB] reset state");
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("rst out_pc",    out_pc,             32'd0);
    checkOutput("rst out_imm",   out_imm,            32'd0);
    checkOutput("rst ctrl",      {23'b0, ctrl_act},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] decode table");
    for (int i = 0; i < NVEC; i++) begin
      pc = 32'h1000 + 32'(i * 4);
      applyStimulus(1'b1, vecs[i].instr, pc, 1'b1, 1'b0);
      checkOutput($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("v%0d valid", i),  {31'b0, out_valid},  32'd1);
      checkOutput($sformatf("v%0d pc", i),     out_pc,              pc);
      checkOutput($sformatf("v%0d opcode", i), {25'b0, out_opcode}, {25'b0, vecs[i].instr[6:0]});
      checkOutput($sformatf("v%0d rd", i),     {27'b0, out_rd},     {27'b0, vecs[i].rd});
      checkOutput($sformatf("v%0d rs1", i),    {27'b0, out_rs1},    {27'b0, vecs[i].instr[19:15]});
      checkOutput($sformatf("v%0d rs2", i),    {27'b0, out_rs2},    {27'b0, vecs[i].instr[24:20]});
      checkOutput($sformatf("v%0d f3", i),     {29'b0, out_f3},     {29'b0, vecs[i].instr[14:12]});
      checkOutput($sformatf("v%0d f7", i),     {25'b0, out_f7},     {25'b0, vecs[i].instr[31:25]});
      checkOutput($sformatf("v%0d imm", i),    out_imm,             vecs[i].imm);
      checkOutput($sformatf("v%0d ctrl", i),   {23'b0, ctrl_act},   {23'b0, vecs[i].ctrl});
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'hFFF00093, 32'h1800, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h123452B7, 32'h1804, 1'b1, 1'b0);
    checkOutput("b2b first pc",  out_pc,  32'h1800);
    checkOutput("b2b in_ready",  {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("b2b second valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b second pc",  out_pc,  32'h1804);
    checkOutput("b2b second imm", out_imm, 32'h12345000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h123452B7, 32'h2000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'hFFF00093, 32'h2004, 1'b0, 1'b0);
      checkOutput($sformatf("bp%0d valid", k),    {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("bp%0d in_ready", k), {31'b0, in_ready},  32'd0);
      checkOutput($sformatf("bp%0d pc", k),       out_pc,             32'h2000);
      checkOutput($sformatf("bp%0d imm", k),      out_imm,            32'h12345000);
      checkOutput($sformatf("bp%0d rd", k),       {27'b0, out_rd},    32'd5);
    end
    applyStimulus(1'b1, 32'hFFF00093, 32'h2004, 1'b1, 1'b0);
    checkOutput("bp release in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp release pc",       out_pc,            32'h2000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp second valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp second pc",    out_pc,             32'h2004);
    checkOutput("bp second imm",   out_imm,            32'hFFFFFFFF);
    checkOutput("bp second rd",    {27'b0, out_rd},    32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp drained", {31'b0, out_valid}, 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h0020A423, 32'h3000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFC12183, 32'h3004, 1'b0, 1'b1);
    checkOutput("fl held valid",   {31'b0, out_valid}, 32'd1);
    checkOutput("fl in_ready",     {31'b0, in_ready},  32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl valid after",  {31'b0, out_valid}, 32'd0);
    checkOutput("fl in_ready after", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'h010000EF, 32'h3008, 1'b1, 1'b1);
    checkOutput("fl empty in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl empty dropped",  {31'b0, out_valid}, 32'd0);

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 32'h010000EF, 32'h4000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("mr held valid", {31'b0, out_valid}, 32'd1);
    checkOutput("mr held jump",  {31'b0, out_jump},  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr valid",    {31'b0, out_valid}, 32'd0);
    checkOutput("mr in_ready", {31'b0, in_ready},  32'd1);
    checkOutput("mr pc",       out_pc,             32'd0);
    checkOutput("mr imm",      out_imm,            32'd0);
    checkOutput("mr rd",       {27'b0, out_rd},    32'd0);
    checkOutput("mr ctrl",     {23'b0, ctrl_act},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("mr after release", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
